line_cache: RTL and testbench
=============================

LINE_CACHE -- requirements
Module: line_cache

Interface
REQ-001 SHALL have parameter LINEWIDTH, default 240, GBA pixels per line.
REQ-002 SHALL have parameter LINECOUNT, default 160, GBA lines per frame.
REQ-003 SHALL have parameter NBUF, default 4, line buffers in ring (power of two, >=4).
REQ-004 SHALL have ports pxlClk in 1 (sole clock); rst in 1 (reset, asynchronous, active-high).
REQ-005 SHALL have ports wrValid in 1 (pixel strobe); wrRed/wrGreen/wrBlue in 8 each (pixel data); wrFrameStart in 1 (first pixel of frame follows).
REQ-006 SHALL have ports curPxl in 8 (read column); nextLine in 1 (advance read row); cacheUpdate in 1 (latch row selection).
REQ-007 SHALL have outputs {prevLine,curLine,nextLine}{Prev,Cur,Next}Pxl{Red,Green,Blue}, 8 bits each, forming a 3x3 neighbourhood.
REQ-008 SHALL have outputs sameLine out 1; newFrame out 1 (pulse); overflow out 1 (sticky).

Function
REQ-009 Writer FSM SHALL have states WAIT_FRAME and CAPTURE; reset enters WAIT_FRAME; wrFrameStart enters CAPTURE from either state.
REQ-010 In WAIT_FRAME, wrValid SHALL be ignored.
REQ-011 In CAPTURE, each wrValid SHALL write RGB to buffer wrBuf, column wrX, then increment wrX.
REQ-012 When wrX = LINEWIDTH-1 is written: wrX->0, wrBuf->wrBuf+1 mod NBUF, wrY+1, linesDone+1.
REQ-013 When wrY reaches LINECOUNT, the FSM SHALL return to WAIT_FRAME.
REQ-014 wrFrameStart SHALL clear wrX, wrY, wrBuf, rdBuf, rdY and linesDone, and SHALL pulse newFrame for exactly one cycle on the next edge.
REQ-015 wrFrameStart coincident with wrValid SHALL apply the frame reset first, then write that pixel to column 0 of buffer 0.
REQ-016 wrFrameStart coincident with nextLine SHALL take precedence; nextLine is discarded.
REQ-017 nextLine SHALL advance rdBuf mod NBUF and rdY (saturating at LINECOUNT-1) and decrement linesDone.
REQ-018 sameLine SHALL be combinationally 1 whenever linesDone < 2 (next row not yet complete); nextLine while sameLine=1 SHALL be ignored.
REQ-019 If a line completion would make linesDone exceed NBUF-2, overflow SHALL set; the write SHALL proceed regardless.
REQ-020 overflow SHALL clear only on rst.
REQ-021 cacheUpdate SHALL latch prev/cur/next buffer indices from rdBuf (post-increment value if nextLine is in the same cycle).
REQ-022 Row clamp on latch: rdY=0 -> prev row = cur row; rdY=LINECOUNT-1 -> next row = cur row.
REQ-023 Column clamp: curPxl=0 -> Prev column = 0; curPxl=LINEWIDTH-1 -> Next column = LINEWIDTH-1; curPxl >= LINEWIDTH reads as LINEWIDTH-1.
REQ-024 Read latency SHALL be exactly 1 cycle: outputs on edge n+1 reflect curPxl and the latched rows at edge n.
REQ-025 A same-cycle write and read of one address SHALL return old data.

Reset
REQ-026 rst SHALL zero all counters, pointers, latched selections, newFrame, overflow and all pixel outputs; sameLine SHALL read 1.
REQ-027 Buffer RAM contents SHALL NOT be reset.
REQ-028 rst mid-line SHALL discard the partial line; capture resumes only after the next wrFrameStart.

Configuration
REQ-029 Macro LINE_CACHE_NEIGHBOR_EN defined: full 3x3 outputs per REQ-007 and REQ-021..023.
REQ-030 Without it: only curLineCurPxl* are read from RAM; all other neighbourhood outputs equal curLineCurPxl*; latency stays 1 cycle; one read port per buffer.

Structure
REQ-031 LINEWIDTH/LINECOUNT defaults and the RGB pixel struct typedef SHALL live in definePackage.
REQ-032 One sub-module, line_cache_ram (1 write, 3 read ports, registered reads), SHALL be instantiated NBUF times.

Verification
REQ-033 Reset, then wrFrameStart + 240 wrValid with R=column -> linesDone=1, sameLine=1; second line -> sameLine=0.
REQ-034 Two lines captured, cacheUpdate, curPxl=0 then 100 then 239 -> curLineCurPxlRed=0/100/239 one cycle later; Prev at 0 = 0; Next at 239 = 239; prev row = cur row (rdY=0).
REQ-035 nextLine+cacheUpdate same cycle after 3 lines -> cur row = line 1, prev = line 0, next = line 2.
REQ-036 Capture 4 lines without nextLine -> overflow=1, remains 1 after wrFrameStart, clears on rst.
REQ-037 wrFrameStart mid-line at wrX=57 with nextLine -> newFrame pulse 1 cycle, wrX=0, rdY=0, nextLine ignored.
REQ-038 rst asserted asynchronously mid-write -> all outputs 0 without waiting for a clock edge; wrValid ignored until wrFrameStart.

Source files
------------

// File: rtl/definePackage.sv
// Shared definitions for the line cache: default frame geometry, the RGB
// pixel type stored in the line buffers, and the writer state encoding.
package definePackage;

   localparam int LINEWIDTH_DEF = 240;
   localparam int LINECOUNT_DEF = 160;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } pixel_t;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      CAPTURE    = 1'b1
   } wr_state_t;

endpackage

// File: rtl/line_cache_ram.sv
// One line buffer: a single write port and RD_PORTS registered read ports.
// A read of the address being written in the same cycle returns the old data.
// Storage is never reset; only the read registers clear on rst so the cache
// outputs go to zero immediately.
module line_cache_ram
   import definePackage::*;
#(
   parameter int DEPTH    = 240,
   parameter int RD_PORTS = 3
) (
   input  logic                                    pxlClk,
   input  logic                                    rst,
   input  logic                                    we,
   input  logic [$clog2(DEPTH)-1:0]                wrAddr,
   input  pixel_t                                  wrData,
   input  logic [RD_PORTS-1:0][$clog2(DEPTH)-1:0]  rdAddr,
   output pixel_t [RD_PORTS-1:0]                   rdData
);

   pixel_t mem [DEPTH];

   // Pixel storage write port
   always_ff @(posedge pxlClk) begin
      if (we) mem[wrAddr] <= wrData;
   end

   // Registered read ports (read-before-write)
   always_ff @(posedge pxlClk or posedge rst) begin
      if (rst) begin
         rdData <= '0;
      end else begin
         for (int p = 0; p < RD_PORTS; p++) rdData[p] <= mem[rdAddr[p]];
      end
   end

endmodule

// File: rtl/line_cache.sv
// Ring of NBUF line buffers between a GBA pixel stream and a 3x3
// neighbourhood reader. The writer fills one line per buffer; the reader
// steps rows with nextLine and latches its row selection with cacheUpdate.
// Optional feature macro: LINE_CACHE_NEIGHBOR_EN (full 3x3 read-out). When
// undefined only the centre pixel is read and it drives all nine outputs.
module line_cache
   import definePackage::*;
#(
   parameter int LINEWIDTH = LINEWIDTH_DEF,
   parameter int LINECOUNT = LINECOUNT_DEF,
   parameter int NBUF      = 4
) (
   input  logic       pxlClk,
   input  logic       rst,
   input  logic       wrValid,
   input  logic [7:0] wrRed,
   input  logic [7:0] wrGreen,
   input  logic [7:0] wrBlue,
   input  logic       wrFrameStart,
   input  logic [7:0] curPxl,
   input  logic       nextLine,
   input  logic       cacheUpdate,
   output logic [7:0] prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue,
   output logic [7:0] prevLineCurPxlRed,  prevLineCurPxlGreen,  prevLineCurPxlBlue,
   output logic [7:0] prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue,
   output logic [7:0] curLinePrevPxlRed,  curLinePrevPxlGreen,  curLinePrevPxlBlue,
   output logic [7:0] curLineCurPxlRed,   curLineCurPxlGreen,   curLineCurPxlBlue,
   output logic [7:0] curLineNextPxlRed,  curLineNextPxlGreen,  curLineNextPxlBlue,
   output logic [7:0] nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue,
   output logic [7:0] nextLineCurPxlRed,  nextLineCurPxlGreen,  nextLineCurPxlBlue,
   output logic [7:0] nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue,
   output logic       sameLine,
   output logic       newFrame,
   output logic       overflow
);

   localparam int XW = $clog2(LINEWIDTH);
   localparam int YW = $clog2(LINECOUNT + 1);
   localparam int BW = $clog2(NBUF);
   localparam logic [XW-1:0] X_LAST = XW'(LINEWIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(LINECOUNT - 1);
   localparam logic [YW-1:0] Y_END  = YW'(LINECOUNT);

`ifdef LINE_CACHE_NEIGHBOR_EN
   localparam int RDP = 3;
`else
   localparam int RDP = 1;
`endif

   function automatic logic [XW-1:0] clamp_col(input logic [7:0] px);
      if (int'(px) > LINEWIDTH - 1) return X_LAST;
      return XW'(px);
   endfunction

   wr_state_t     state;
   logic [XW-1:0] wrX;
   logic [YW-1:0] wrY, rdY, linesDone;
   logic [BW-1:0] wrBuf, rdBuf;

   logic [XW-1:0] eff_x;
   logic [YW-1:0] eff_y, eff_ld, eff_ry, ld_next, ry_next;
   logic [BW-1:0] eff_buf, eff_rb, rb_next;
   logic          wr_en, line_done, nl;

   assign sameLine = (linesDone < YW'(2));

   // A frame start zeroes the pointers before this cycle's write/advance is applied
   always_comb begin
      eff_x     = wrFrameStart ? '0 : wrX;
      eff_y     = wrFrameStart ? '0 : wrY;
      eff_ld    = wrFrameStart ? '0 : linesDone;
      eff_buf   = wrFrameStart ? '0 : wrBuf;
      eff_rb    = wrFrameStart ? '0 : rdBuf;
      eff_ry    = wrFrameStart ? '0 : rdY;
      wr_en     = wrValid && (wrFrameStart || (state == CAPTURE));
      line_done = wr_en && (eff_x == X_LAST);
      nl        = nextLine && !wrFrameStart && !sameLine;
      ld_next   = eff_ld + YW'(line_done) - YW'(nl);
      rb_next   = nl ? (rdBuf + 1'b1) : eff_rb;
      ry_next   = (nl && (rdY != Y_LAST)) ? (rdY + 1'b1) : eff_ry;
   end

   // Writer FSM, ring pointers, line accounting and status flags
   always_ff @(posedge pxlClk or posedge rst) begin
      if (rst) begin
         state     <= WAIT_FRAME;
         wrX       <= '0;
         wrY       <= '0;
         wrBuf     <= '0;
         rdBuf     <= '0;
         rdY       <= '0;
         linesDone <= '0;
         newFrame  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         newFrame  <= wrFrameStart;
         wrX       <= eff_x;
         wrY       <= eff_y;
         wrBuf     <= eff_buf;
         rdBuf     <= rb_next;
         rdY       <= ry_next;
         linesDone <= ld_next;
         if (wrFrameStart) state <= CAPTURE;
         if (wr_en) begin
            if (line_done) begin
               wrX   <= '0;
               wrBuf <= eff_buf + 1'b1;
               wrY   <= eff_y + 1'b1;
               if (eff_y + 1'b1 == Y_END) state <= WAIT_FRAME;
               if (ld_next > YW'(NBUF - 2)) overflow <= 1'b1;
            end else begin
               wrX <= eff_x + 1'b1;
            end
         end
      end
   end

   logic [XW-1:0]           c_cur;
   logic [RDP-1:0][XW-1:0]  rd_addr;
   pixel_t [RDP-1:0]        rd_q_p1 [NBUF];
   pixel_t                  wr_pix;
   pixel_t                  pix_pp, pix_pc, pix_pn, pix_cp, pix_cc, pix_cn, pix_np, pix_nc, pix_nn;

   assign wr_pix = '{red: wrRed, green: wrGreen, blue: wrBlue};
   assign c_cur  = clamp_col(curPxl);

`ifdef LINE_CACHE_NEIGHBOR_EN
   logic [BW-1:0] sel_prev, sel_cur, sel_next;

   assign rd_addr[0] = (c_cur == '0) ? '0 : (c_cur - 1'b1);
   assign rd_addr[1] = c_cur;
   assign rd_addr[2] = (c_cur == X_LAST) ? X_LAST : (c_cur + 1'b1);

   // Latch the three row buffers, clamping at the top and bottom of the frame
   always_ff @(posedge pxlClk or posedge rst) begin
      if (rst) begin
         sel_prev <= '0;
         sel_cur  <= '0;
         sel_next <= '0;
      end else if (cacheUpdate) begin
         sel_cur  <= rb_next;
         sel_prev <= (ry_next == '0)    ? rb_next : (rb_next - 1'b1);
         sel_next <= (ry_next == Y_LAST) ? rb_next : (rb_next + 1'b1);
      end
   end

   assign pix_pp = rd_q_p1[sel_prev][0];
   assign pix_pc = rd_q_p1[sel_prev][1];
   assign pix_pn = rd_q_p1[sel_prev][2];
   assign pix_cp = rd_q_p1[sel_cur][0];
   assign pix_cc = rd_q_p1[sel_cur][1];
   assign pix_cn = rd_q_p1[sel_cur][2];
   assign pix_np = rd_q_p1[sel_next][0];
   assign pix_nc = rd_q_p1[sel_next][1];
   assign pix_nn = rd_q_p1[sel_next][2];
`else
   logic [BW-1:0] sel_cur;

   assign rd_addr[0] = c_cur;

   // Latch the current row buffer
   always_ff @(posedge pxlClk or posedge rst) begin
      if (rst)              sel_cur <= '0;
      else if (cacheUpdate) sel_cur <= rb_next;
   end

   assign pix_cc = rd_q_p1[sel_cur][0];
   assign pix_pp = pix_cc;
   assign pix_pc = pix_cc;
   assign pix_pn = pix_cc;
   assign pix_cp = pix_cc;
   assign pix_cn = pix_cc;
   assign pix_np = pix_cc;
   assign pix_nc = pix_cc;
   assign pix_nn = pix_cc;
`endif

   // ---- read stage p1: registered RAM outputs ----
   for (genvar b = 0; b < NBUF; b++) begin : g_buf
      line_cache_ram #(
         .DEPTH    (LINEWIDTH),
         .RD_PORTS (RDP)
      ) u_ram (
         .pxlClk (pxlClk),
         .rst    (rst),
         .we     (wr_en && (eff_buf == BW'(b))),
         .wrAddr (eff_x),
         .wrData (wr_pix),
         .rdAddr (rd_addr),
         .rdData (rd_q_p1[b])
      );
   end

   assign {prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue} = pix_pp;
   assign {prevLineCurPxlRed,  prevLineCurPxlGreen,  prevLineCurPxlBlue}  = pix_pc;
   assign {prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue} = pix_pn;
   assign {curLinePrevPxlRed,  curLinePrevPxlGreen,  curLinePrevPxlBlue}  = pix_cp;
   assign {curLineCurPxlRed,   curLineCurPxlGreen,   curLineCurPxlBlue}   = pix_cc;
   assign {curLineNextPxlRed,  curLineNextPxlGreen,  curLineNextPxlBlue}  = pix_cn;
   assign {nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue} = pix_np;
   assign {nextLineCurPxlRed,  nextLineCurPxlGreen,  nextLineCurPxlBlue}  = pix_nc;
   assign {nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue} = pix_nn;

endmodule

// File: tb/tb_line_cache.sv
// Scoreboard bench for line_cache: each read request pushes the expected
// 3x3 neighbourhood; a monitor pops and compares one cycle later.
module tb_line_cache;

   localparam int VW = 216;
   localparam int LW = 240;

   logic       pxlClk, rst;
   logic       wrValid, wrFrameStart, nextLine, cacheUpdate;
   logic [7:0] wrRed, wrGreen, wrBlue, curPxl;
   logic [7:0] ppR, ppG, ppB, pcR, pcG, pcB, pnR, pnG, pnB;
   logic [7:0] cpR, cpG, cpB, ccR, ccG, ccB, cnR, cnG, cnB;
   logic [7:0] npR, npG, npB, ncR, ncG, ncB, nnR, nnG, nnB;
   logic       sameLine, newFrame, overflow;

   line_cache dut (
      .pxlClk(pxlClk), .rst(rst), .wrValid(wrValid),
      .wrRed(wrRed), .wrGreen(wrGreen), .wrBlue(wrBlue),
      .wrFrameStart(wrFrameStart), .curPxl(curPxl),
      .nextLine(nextLine), .cacheUpdate(cacheUpdate),
      .prevLinePrevPxlRed(ppR), .prevLinePrevPxlGreen(ppG), .prevLinePrevPxlBlue(ppB),
      .prevLineCurPxlRed(pcR),  .prevLineCurPxlGreen(pcG),  .prevLineCurPxlBlue(pcB),
      .prevLineNextPxlRed(pnR), .prevLineNextPxlGreen(pnG), .prevLineNextPxlBlue(pnB),
      .curLinePrevPxlRed(cpR),  .curLinePrevPxlGreen(cpG),  .curLinePrevPxlBlue(cpB),
      .curLineCurPxlRed(ccR),   .curLineCurPxlGreen(ccG),   .curLineCurPxlBlue(ccB),
      .curLineNextPxlRed(cnR),  .curLineNextPxlGreen(cnG),  .curLineNextPxlBlue(cnB),
      .nextLinePrevPxlRed(npR), .nextLinePrevPxlGreen(npG), .nextLinePrevPxlBlue(npB),
      .nextLineCurPxlRed(ncR),  .nextLineCurPxlGreen(ncG),  .nextLineCurPxlBlue(ncB),
      .nextLineNextPxlRed(nnR), .nextLineNextPxlGreen(nnG), .nextLineNextPxlBlue(nnB),
      .sameLine(sameLine), .newFrame(newFrame), .overflow(overflow)
   );

   logic [VW-1:0] obs_vec;
   assign obs_vec = {ppR, ppG, ppB, pcR, pcG, pcB, pnR, pnG, pnB,
                     cpR, cpG, cpB, ccR, ccG, ccB, cnR, cnG, cnB,
                     npR, npG, npB, ncR, ncG, ncB, nnR, nnG, nnB};

   int n_cmp = 0;
   int n_err = 0;

   logic [VW-1:0] exp_q [$];
   string         tag_q [$];
   logic          rd_strobe = 1'b0;
   logic          rd_issued = 1'b0;
   logic [VW-1:0] sb_exp;
   string         sb_tag;

   task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference pixel for a given line tag and column; red carries the column.
   function automatic logic [23:0] pix(input int line, input int col);
      logic [7:0] r, g, b;
      r = 8'(col);
      g = 8'(line + 64);
      b = 8'((col * 3) ^ (line * 29));
      return {r, g, b};
   endfunction

   initial pxlClk = 1'b0;
   always #5 pxlClk = ~pxlClk;

   always @(posedge pxlClk) rd_issued <= rd_strobe;

   // Monitor: compare DUT neighbourhood against the oldest pending expectation
   always @(negedge pxlClk) begin
      if (rd_issued) begin
         if (exp_q.size() == 0) begin
            check_val("sb_underflow", VW'(1), VW'(0));
         end else begin
            sb_exp = exp_q.pop_front();
            sb_tag = tag_q.pop_front();
            check_val(sb_tag, obs_vec, sb_exp);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Drive columns c0..c1 of a line, one pixel per cycle, optional frame start on the first
   task automatic send_pixels(input int line, input int c0, input int c1, input bit start);
      for (int c = c0; c <= c1; c++) begin
         wrValid = 1'b1;
         {wrRed, wrGreen, wrBlue} = pix(line, c);
         wrFrameStart = start && (c == c0);
         @(negedge pxlClk);
      end
      wrValid = 1'b0;
      wrFrameStart = 1'b0;
   endtask

   task automatic pulse_update();
      cacheUpdate = 1'b1;
      @(negedge pxlClk);
      cacheUpdate = 1'b0;
   endtask

   // Issue one read and push the expected neighbourhood for rows (lp, lc, ln)
   task automatic rd(input string tag, input int lp, input int lc, input int ln, input int col);
      int cc, cp, cn;
      logic [VW-1:0] e;
      cc = (col > LW - 1) ? LW - 1 : col;
      cp = (cc == 0) ? 0 : cc - 1;
      cn = (cc == LW - 1) ? LW - 1 : cc + 1;
      e = {pix(lp, cp), pix(lp, cc), pix(lp, cn),
           pix(lc, cp), pix(lc, cc), pix(lc, cn),
           pix(ln, cp), pix(ln, cc), pix(ln, cn)};
`ifndef LINE_CACHE_NEIGHBOR_EN
      e = {9{pix(lc, cc)}};
`endif
      curPxl = 8'(col);
      rd_strobe = 1'b1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge pxlClk);
      rd_strobe = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wrValid = 1'b0; wrFrameStart = 1'b0; nextLine = 1'b0; cacheUpdate = 1'b0;
      wrRed = 8'd0; wrGreen = 8'd0; wrBlue = 8'd0; curPxl = 8'd0;
      repeat (3) @(negedge pxlClk);
      check_val("rst_pix", obs_vec, VW'(0));
      check_val("rst_sameLine", VW'(sameLine), VW'(1));
      check_val("rst_overflow", VW'(overflow), VW'(0));
      check_val("rst_newFrame", VW'(newFrame), VW'(0));
      rst = 1'b0;
      @(negedge pxlClk);

      // First two lines: sameLine drops only once the second line completes
      send_pixels(0, 0, LW - 1, 1'b1);
      check_val("line1_sameLine", VW'(sameLine), VW'(1));
      send_pixels(1, 0, LW - 1, 1'b0);
      check_val("line2_sameLine", VW'(sameLine), VW'(0));
      check_val("line2_overflow", VW'(overflow), VW'(0));

      // Row 0: prev row clamps to the current row
      pulse_update();
      rd("r0_col0",   0, 0, 1, 0);
      rd("r0_col100", 0, 0, 1, 100);
      rd("r0_col239", 0, 0, 1, 239);
      rd("r0_col250", 0, 0, 1, 250);

      // Third line pushes linesDone past NBUF-2
      send_pixels(2, 0, LW - 1, 1'b0);
      check_val("line3_overflow", VW'(overflow), VW'(1));

      // nextLine and cacheUpdate together latch the advanced row
      nextLine = 1'b1;
      cacheUpdate = 1'b1;
      @(negedge pxlClk);
      nextLine = 1'b0;
      cacheUpdate = 1'b0;
      check_val("adv_sameLine", VW'(sameLine), VW'(0));
      rd("r1_col0",   0, 1, 2, 0);
      rd("r1_col57",  0, 1, 2, 57);
      rd("r1_col239", 0, 1, 2, 239);

      // Fourth line, then a partial fifth line up to wrX=57
      send_pixels(3, 0, LW - 1, 1'b0);
      check_val("line4_overflow", VW'(overflow), VW'(1));
      send_pixels(4, 0, 56, 1'b0);

      // Frame start mid-line together with nextLine and a pixel
      wrValid = 1'b1;
      wrFrameStart = 1'b1;
      nextLine = 1'b1;
      {wrRed, wrGreen, wrBlue} = pix(20, 0);
      @(negedge pxlClk);
      check_val("fs_newFrame_hi", VW'(newFrame), VW'(1));
      wrFrameStart = 1'b0;
      nextLine = 1'b0;
      {wrRed, wrGreen, wrBlue} = pix(20, 1);
      @(negedge pxlClk);
      check_val("fs_newFrame_lo", VW'(newFrame), VW'(0));
      send_pixels(20, 2, LW - 1, 1'b0);
      check_val("fs_line1_sameLine", VW'(sameLine), VW'(1));
      check_val("fs_overflow_kept", VW'(overflow), VW'(1));
      send_pixels(21, 0, LW - 1, 1'b0);
      check_val("fs_line2_sameLine", VW'(sameLine), VW'(0));
      pulse_update();
      rd("fs_col0",   20, 20, 21, 0);
      rd("fs_col57",  20, 20, 21, 57);
      rd("fs_col239", 20, 20, 21, 239);

      // Asynchronous reset in the middle of a write
      send_pixels(22, 0, 29, 1'b0);
      wrValid = 1'b1;
      {wrRed, wrGreen, wrBlue} = pix(22, 30);
      @(posedge pxlClk);
      #2 rst = 1'b1;
      #1;
      check_val("arst_pix", obs_vec, VW'(0));
      check_val("arst_overflow", VW'(overflow), VW'(0));
      check_val("arst_newFrame", VW'(newFrame), VW'(0));
      check_val("arst_sameLine", VW'(sameLine), VW'(1));
      @(negedge pxlClk);
      wrValid = 1'b0;
      @(negedge pxlClk);
      rst = 1'b0;
      @(negedge pxlClk);

      // Pixels without a frame start are ignored after reset
      send_pixels(30, 0, LW - 1, 1'b0);
      send_pixels(31, 0, LW - 1, 1'b0);
      check_val("ign_sameLine", VW'(sameLine), VW'(1));

      send_pixels(40, 0, LW - 1, 1'b1);
      send_pixels(41, 0, LW - 1, 1'b0);
      check_val("post_sameLine", VW'(sameLine), VW'(0));
      check_val("post_overflow", VW'(overflow), VW'(0));
      pulse_update();
      rd("post_col5",   40, 40, 41, 5);
      rd("post_col250", 40, 40, 41, 250);

      repeat (2) @(negedge pxlClk);
      check_val("sb_drain", VW'(exp_q.size()), VW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
